// File: rtl/dsp_macc_arbiter_pkg.sv
// Shared widths, requester count and FSM state type for the MAC arbiter.
package dsp_macc_arbiter_pkg;

    localparam int unsigned A_W  = 20;
    localparam int unsigned B_W  = 18;
    localparam int unsigned Z_W  = 38;
    localparam int unsigned NREQ = 2;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain,
        StResult
    } state_e;

endpackage

// File: rtl/dsp_macc_arbiter_rr_arb2.sv
// Two-way round-robin grant: a single pointer names the preferred requester when both ask.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] request,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant
);

    logic ptr_q;

    // After a served job, prefer the other requester next time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 1'b0;
        end else if (update) begin
            ptr_q <= ~served;
        end
    end

    // Single requester wins outright; a tie goes to the pointer.
    always_comb begin
        grant = request;
        if (request == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dsp_macc_arbiter.sv
// Arbitrates two operand streams onto one external multiply-accumulate datapath and
// returns each job's accumulated result through a valid/ready handshake.
module dsp_macc_arbiter
    import dsp_macc_arbiter_pkg::*;
#(
    parameter int unsigned MAC_LAT   = 1,
    parameter int unsigned MAX_TERMS = 256,
    parameter logic [79:0] MODE_BITS = 80'd0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0][A_W-1:0]  req_a,
    input  logic [NREQ-1:0][B_W-1:0]  req_b,
    input  logic [NREQ-1:0]           req_last,
    input  logic [NREQ-1:0]           req_sub,
    output logic [A_W-1:0]            mac_a,
    output logic [B_W-1:0]            mac_b,
    output logic                      mac_load_acc,
    output logic                      mac_subtract,
    output logic                      mac_en,
    output logic [79:0]               mac_mode_bits,
    input  logic [Z_W-1:0]            mac_z,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      res_id,
    output logic [Z_W-1:0]            res_z,
    output logic                      res_ovf
);

    localparam int unsigned CNT_W = $clog2(MAX_TERMS) + 1;
    localparam int unsigned LAT_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_TERMS);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MAC_LAT);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              ovf_q, ovf_d;
    logic [Z_W-1:0]    z_q, z_d;
    logic [NREQ-1:0]   arb_grant;
    logic              sel;
    logic              beat;
    logic              hs;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .request (req_valid),
        .update  (hs),
        .served  (gnt_q),
        .grant   (arb_grant)
    );

    assign mac_mode_bits = MODE_BITS;
    assign res_valid     = (state_q == StResult);
    assign res_id        = gnt_q;
    assign res_z         = z_q;
    assign res_ovf       = ovf_q;
    assign cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, beat pass-through and MAC control.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        ovf_d        = ovf_q;
        z_d          = z_q;
        req_ready    = '0;
        mac_en       = 1'b0;
        mac_a        = '0;
        mac_b        = '0;
        mac_subtract = 1'b0;
        mac_load_acc = 1'b0;
        sel          = gnt_q;
        beat         = 1'b0;
        hs           = 1'b0;

        unique case (state_q)
            StIdle: begin
                // First beat is taken straight from the arbiter; ready only with valid.
                sel       = arb_grant[1];
                req_ready = arb_grant & {NREQ{reset}};
                beat      = |req_ready;
            end
            StAccum: begin
                req_ready[gnt_q] = 1'b1;
                beat             = req_valid[gnt_q];
                mac_load_acc     = 1'b1;
            end
            StDrain: begin
                mac_load_acc = 1'b1;
                if (lat_q == '0) begin
                    z_d     = mac_z;
                    state_d = StResult;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            StResult: begin
                mac_load_acc = 1'b1;
                if (res_ready) begin
                    hs      = 1'b1;
                    state_d = StIdle;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (beat) begin
            mac_en       = 1'b1;
            mac_a        = req_a[sel];
            mac_b        = req_b[sel];
            mac_subtract = req_sub[sel];
            gnt_d        = sel;
            cnt_d        = cnt_inc;
            if (!req_last[sel] && (cnt_inc == CNT_MAX)) begin
                ovf_d = 1'b1;
            end
            if (req_last[sel]) begin
                state_d = StDrain;
                lat_d   = LAT_INIT;
            end else begin
                state_d = StAccum;
            end
        end
    end

    // State and result registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            gnt_q   <= 1'b0;
            cnt_q   <= '0;
            lat_q   <= '0;
            ovf_q   <= 1'b0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            ovf_q   <= ovf_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_dsp_macc_arbiter.sv
// Directed bench for dsp_macc_arbiter with a behavioural MAC and a job-level scoreboard.
module tb_dsp_macc_arbiter;
    import dsp_macc_arbiter_pkg::*;

    localparam int unsigned MAC_LAT = 1;
    localparam int unsigned MAX_T   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0][19:0]  req_a = '0;
    logic [1:0][17:0]  req_b = '0;
    logic [1:0]        req_last = '0;
    logic [1:0]        req_sub = '0;
    logic [19:0]       mac_a;
    logic [17:0]       mac_b;
    logic              mac_load_acc, mac_subtract, mac_en;
    logic [79:0]       mac_mode_bits;
    logic [37:0]       mac_z = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic              res_id;
    logic [37:0]       res_z;
    logic              res_ovf;

    dsp_macc_arbiter #(
        .MAC_LAT   (MAC_LAT),
        .MAX_TERMS (MAX_T),
        .MODE_BITS (80'd0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_last      (req_last),
        .req_sub       (req_sub),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_load_acc  (mac_load_acc),
        .mac_subtract  (mac_subtract),
        .mac_en        (mac_en),
        .mac_mode_bits (mac_mode_bits),
        .mac_z         (mac_z),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_id        (res_id),
        .res_z         (res_z),
        .res_ovf       (res_ovf)
    );

    always #5 clk = ~clk;

    // External MULTACC stand-in with one cycle of latency.
    wire [37:0] mac_p = {18'd0, mac_a} * {20'd0, mac_b};
    always @(posedge clk) begin
        if (mac_en) begin
            if (mac_load_acc) mac_z <= mac_subtract ? mac_z - mac_p : mac_z + mac_p;
            else              mac_z <= mac_subtract ? 38'd0 - mac_p : mac_p;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        id;
        logic [19:0] a;
        logic [17:0] b;
        logic        sub;
        logic        load;
    } beat_t;

    typedef struct {
        logic        id;
        logic [37:0] z;
        logic        ovf;
    } job_t;

    beat_t beat_q[$];
    job_t  job_q[$];

    int ja[2][8];
    int jb[2][8];
    bit js[2][8];
    int jn[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (bound expired or unexpected event)", name);
    endtask

    // Expected beats of the first k terms; the job result is sum of +/- a*b over all terms.
    task automatic model_job(input int r, input int k, input bit with_result);
        logic [37:0] z;
        beat_t bt;
        job_t jt;
        z = '0;
        for (int i = 0; i < k; i++) begin
            longint p;
            p = longint'(ja[r][i]) * longint'(jb[r][i]);
            z = js[r][i] ? z - 38'(p) : z + 38'(p);
            bt.id   = r[0];
            bt.a    = 20'(ja[r][i]);
            bt.b    = 18'(jb[r][i]);
            bt.sub  = js[r][i];
            bt.load = (i != 0);
            beat_q.push_back(bt);
        end
        if (with_result) begin
            jt.id  = r[0];
            jt.z   = z;
            jt.ovf = (jn[r] > int'(MAX_T));
            job_q.push_back(jt);
        end
    endtask

    task automatic drive(input int r, input int k);
        for (int i = 0; i < k; i++) begin
            int w;
            w = 0;
            req_valid[r] = 1'b1;
            req_a[r]     = 20'(ja[r][i]);
            req_b[r]     = 18'(jb[r][i]);
            req_sub[r]   = js[r][i];
            req_last[r]  = (i == jn[r] - 1);
            @(negedge clk);
            while (!req_ready[r] && w < 100) begin
                w++;
                @(negedge clk);
            end
            if (!req_ready[r]) begin
                fail($sformatf("ready_timeout_r%0d", r));
                req_valid[r] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
        req_sub[r]   = 1'b0;
        req_a[r]     = '0;
        req_b[r]     = '0;
    endtask

    task automatic wait_result();
        int w;
        w = 0;
        @(negedge clk);
        while (!res_valid && w < 60) begin
            w++;
            @(negedge clk);
        end
        if (!res_valid) fail("result_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_mac_en"}, mac_en, 0);
        check({tag, "_mac_sub"}, mac_subtract, 0);
        check({tag, "_mac_load"}, mac_load_acc, 0);
        check({tag, "_mac_ops"}, {mac_a, mac_b}, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_z"}, res_z, 0);
        check({tag, "_res_id"}, res_id, 0);
        check({tag, "_res_ovf"}, res_ovf, 0);
    endtask

    task automatic set_beat(input int r, input int i, input int a, input int b, input bit s);
        ja[r][i] = a;
        jb[r][i] = b;
        js[r][i] = s;
    endtask

    // Per-cycle comparison of MAC traffic and result handshakes against the scoreboard.
    initial begin : compare
        forever begin
            @(negedge clk);
            if (reset) begin
                if (mac_en) begin
                    if (beat_q.size() == 0) begin
                        fail("unexpected_beat");
                    end else begin
                        beat_t e;
                        e = beat_q.pop_front();
                        check("beat_a", mac_a, e.a);
                        check("beat_b", mac_b, e.b);
                        check("beat_sub", mac_subtract, e.sub);
                        check("beat_load_acc", mac_load_acc, e.load);
                        check("other_ready_low", req_ready[~e.id], 0);
                    end
                end else begin
                    check("idle_operands", {mac_a, mac_b}, 0);
                end
                check("ready_onehot", ($countones(req_ready) <= 1), 1);
                if (res_valid) begin
                    check("ready_in_result", req_ready, 0);
                    if (job_q.size() == 0) begin
                        fail("spurious_result");
                    end else if (res_ready) begin
                        job_t j;
                        j = job_q.pop_front();
                        check("res_id", res_id, j.id);
                        check("res_z", res_z, j.z);
                        check("res_ovf", res_ovf, j.ovf);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        int t1;
        // Reset state, with both requesters already asking.
        #1 reset = 1'b0;
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        check("mode_bits", (mac_mode_bits == 80'd0), 1);
        req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Three-term job on requester 0 with latency check.
        jn[0] = 3;
        set_beat(0, 0, 2, 3, 0);
        set_beat(0, 1, 4, 5, 0);
        set_beat(0, 2, 1, 7, 0);
        model_job(0, 3, 1);
        fork
            drive(0, 3);
        join_none
        t0 = -1;
        for (int k = 0; k < 20 && t0 < 0; k++) begin
            @(negedge clk);
            if (mac_en) t0 = cyc;
        end
        if (t0 < 0) fail("first_beat_timeout");
        wait_result();
        t1 = cyc;
        check("t1_latency", t1 - t0, 3 + MAC_LAT + 1);
        check("t1_z", res_z, 33);
        check("t1_id", res_id, 0);
        @(posedge clk);
        #1;

        // Fresh reset, then both request together: requester 0 first, then requester 1.
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        jn[0] = 2;
        set_beat(0, 0, 3, 3, 0);
        set_beat(0, 1, 2, 2, 0);
        jn[1] = 1;
        set_beat(1, 0, 5, 6, 0);
        model_job(0, 2, 1);
        model_job(1, 1, 1);
        fork
            drive(0, 2);
            drive(1, 1);
        join_none
        wait_result();
        check("t2_first_id", res_id, 0);
        check("t2_first_z", res_z, 13);
        @(posedge clk);
        #1;
        wait_result();
        check("t2_second_id", res_id, 1);
        check("t2_second_z", res_z, 30);
        @(posedge clk);
        #1;

        // Subtract on the last beat, then stall the result for five cycles.
        res_ready = 1'b0;
        jn[1] = 2;
        set_beat(1, 0, 10, 10, 0);
        set_beat(1, 1, 3, 4, 1);
        model_job(1, 2, 1);
        fork
            drive(1, 2);
        join_none
        wait_result();
        check("t3_z", res_z, 88);
        check("t3_id", res_id, 1);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold_valid", res_valid, 1);
            check("t3_hold_z", res_z, 88);
            check("t3_hold_id", res_id, 1);
            check("t3_hold_ready", req_ready, 0);
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_released", res_valid, 0);

        // Six terms against a limit of four: overflow flagged, job still completes.
        jn[0] = 6;
        for (int i = 0; i < 6; i++) set_beat(0, i, 1, 1, 0);
        model_job(0, 6, 1);
        fork
            drive(0, 6);
        join_none
        wait_result();
        check("t4_ovf", res_ovf, 1);
        check("t4_z", res_z, 6);
        @(posedge clk);
        #1;
        check("t4_ovf_cleared", res_ovf, 0);

        // Exactly MAX_TERMS beats: no overflow.
        jn[0] = 4;
        set_beat(0, 0, 2, 2, 0);
        set_beat(0, 1, 3, 3, 0);
        set_beat(0, 2, 1, 1, 0);
        set_beat(0, 3, 5, 5, 0);
        model_job(0, 4, 1);
        drive(0, 4);
        wait_result();
        check("t5_ovf", res_ovf, 0);
        check("t5_z", res_z, 39);
        @(posedge clk);
        #1;

        // One beat past the limit, with a subtraction driving the sum negative.
        jn[0] = 5;
        set_beat(0, 0, 1, 1, 0);
        set_beat(0, 1, 2, 2, 0);
        set_beat(0, 2, 3, 3, 1);
        set_beat(0, 3, 1, 1, 0);
        set_beat(0, 4, 1, 1, 0);
        model_job(0, 5, 1);
        drive(0, 5);
        wait_result();
        check("t5b_ovf", res_ovf, 1);
        check("t5b_z", res_z, 38'h3F_FFFF_FFFE);
        @(posedge clk);
        #1;

        // Reset after two of four beats: job discarded.
        jn[0] = 4;
        set_beat(0, 0, 1, 2, 0);
        set_beat(0, 1, 3, 4, 0);
        set_beat(0, 2, 5, 6, 0);
        set_beat(0, 3, 7, 8, 0);
        model_job(0, 2, 0);
        drive(0, 2);
        reset = 1'b0;
        req_valid = 2'b11;
        #1;
        check_reset_outputs("midjob");
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_no_result", res_valid, 0);
        check("t6_beats_consumed", beat_q.size(), 0);
        @(posedge clk);
        #1;

        // One-term job after the discarded one starts with load_acc = 0.
        jn[0] = 1;
        set_beat(0, 0, 7, 3, 0);
        model_job(0, 1, 1);
        drive(0, 1);
        wait_result();
        check("t7_z", res_z, 21);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        check("jobs_drained", job_q.size(), 0);
        check("beats_drained", beat_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
